// File: rtl/hall_if.sv
// Hall conditioner bus: raw pins and clear in, filtered code and timing measurements out.
// The master side drives the raw pins; the slave side is the conditioner.
interface hall_if #(
    parameter int unsigned period_width = 32
);
    logic [2:0]              hall_raw;
    logic                    clear;
    logic [2:0]              hall_values;
    logic                    hall_edge;
    logic                    hall_invalid;
    logic [period_width-1:0] period;
    logic                    period_valid;
    logic                    stalled;

    modport master (
        output hall_raw, clear,
        input  hall_values, hall_edge, hall_invalid, period, period_valid, stalled
    );

    modport slave (
        input  hall_raw, clear,
        output hall_values, hall_edge, hall_invalid, period, period_valid, stalled
    );
endinterface

// File: rtl/hall_input_conditioner.sv
// Synchronises and debounces the three hall pins, flags 000/111 codes, measures the
// pclk interval between accepted transitions and declares a stall after a timeout.
module hall_input_conditioner #(
    parameter int unsigned clk_freq_hz   = 54_000_000,
    parameter int unsigned filter_cycles = 16,
    parameter int unsigned period_width  = 32,
    parameter int unsigned timeout_ms    = 500
) (
    input  logic  pclk,
    input  logic  preset_n,
    hall_if.slave bus
);
    localparam logic [63:0] TIMEOUT_CYCLES = 64'(clk_freq_hz) / 64'd1000 * 64'(timeout_ms);
    localparam int          CNT_W          = $clog2(filter_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(filter_cycles);
    localparam logic [CNT_W-1:0] CNT_ACC   = CNT_W'(filter_cycles - 1);
    localparam logic [period_width-1:0] TICK_MAX = period_width'(TIMEOUT_CYCLES - 64'd1);

    if (filter_cycles < 1) begin : g_bad_filter
        $error("hall_input_conditioner: filter_cycles must be at least 1");
    end
    if (TIMEOUT_CYCLES < 64'd1 ||
        (period_width < 64 && TIMEOUT_CYCLES > ((64'd1 << period_width) - 64'd1))) begin : g_bad_timeout
        $error("hall_input_conditioner: timeout_cycles does not fit in period_width");
    end

    logic [2:0]              r_sync_p0;
    logic [2:0]              r_sync_p1;
    logic [2:0]              r_cand;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_hall_values;
    logic                    r_hall_edge;
    logic [period_width-1:0] r_tick;
    logic [period_width-1:0] r_period;
    logic                    r_period_valid;
    logic                    r_stalled;
    logic                    r_armed;

    logic w_same;
    logic w_accept;
    logic w_valid_code;
    logic w_timeout;

    assign w_same       = (r_sync_p1 == r_cand);
    assign w_accept     = w_same && (r_cnt == CNT_ACC) && (r_cand != r_hall_values);
    assign w_valid_code = (r_cand != 3'b000) && (r_cand != 3'b111);
    assign w_timeout    = (r_tick == TICK_MAX);

    // Stage p0/p1: two-flop synchroniser, then the candidate/run-length stability filter
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_sync_p0     <= 3'b000;
            r_sync_p1     <= 3'b000;
            r_cand        <= 3'b000;
            r_cnt         <= '0;
            r_hall_values <= 3'b000;
            r_hall_edge   <= 1'b0;
        end else begin
            r_sync_p0   <= bus.hall_raw;
            r_sync_p1   <= r_sync_p0;
            r_hall_edge <= w_accept;
            if (!w_same) begin
                r_cand <= r_sync_p1;
                r_cnt  <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_hall_values <= r_cand;
            end
        end
    end

    // Interval measurement; an accept outranks both clear and the timeout
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_tick         <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b1;
            r_armed        <= 1'b0;
        end else if (w_accept) begin
            r_tick    <= '0;
            r_stalled <= 1'b0;
            r_armed   <= w_valid_code;
            if (bus.clear) begin
                r_period       <= '0;
                r_period_valid <= 1'b0;
            end else if (w_valid_code && r_armed && !r_stalled) begin
                r_period       <= r_tick + period_width'(1);
                r_period_valid <= 1'b1;
            end
        end else begin
            if (bus.clear) begin
                r_tick         <= '0;
                r_period       <= '0;
                r_period_valid <= 1'b0;
                r_armed        <= 1'b0;
            end else if (!w_timeout) begin
                r_tick <= r_tick + period_width'(1);
            end
            // tick parks at its maximum, so the stall condition stays asserted until an accept
            if (w_timeout) begin
                r_stalled      <= 1'b1;
                r_period_valid <= 1'b0;
                r_armed        <= 1'b0;
            end
        end
    end

    assign bus.hall_values  = r_hall_values;
    assign bus.hall_edge    = r_hall_edge;
    assign bus.hall_invalid = (r_hall_values == 3'b000) || (r_hall_values == 3'b111);
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.stalled      = r_stalled;
endmodule
